// File: rtl/riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_ctrl
// Main control FSM for a multicycle RV32 subset datapath (lw, sw, R-type ALU,
// I-type ALU, beq, jal). The FSM state is the only control register; every
// datapath select and write strobe is decoded from the current state plus the
// live mem_ready and zero inputs. A retire pulse and a wrapping retire counter
// track completed instructions. Illegal encodings either park the FSM in TRAP
// (TRAP_ON_ILLEGAL = 1) or retire as a NOP (TRAP_ON_ILLEGAL = 0).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   op           in   [6:0] opcode field of the instruction register
//   funct3       in   [2:0] instr[14:12]
//   funct7b5     in   instr[30]
//   zero         in   ALU zero flag
//   mem_ready    in   memory handshake, access completes in the cycle it is 1
//   pc_write     out  PC write enable
//   ir_write     out  instruction register write enable
//   reg_write    out  register file write enable
//   mem_write    out  data memory write enable
//   adr_src      out  memory address select (0 PC, 1 Result)
//   alu_src_a    out  [1:0] ALU A select (00 PC, 01 OldPC, 10 rs1)
//   alu_src_b    out  [1:0] ALU B select (00 rs2, 01 imm, 10 constant 4)
//   result_src   out  [1:0] result select (00 ALUOut, 01 ReadData, 10 ALUResult)
//   alu_control  out  [2:0] ALU operation
//   state        out  [3:0] current FSM state (debug)
//   illegal      out  sticky trap flag
//   retire       out  one-cycle pulse per retired instruction
//   retire_cnt   out  [CNT_W-1:0] retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             adr_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       alu_control,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // funct3 values the ALU can execute for R-type and I-type instructions
    function automatic logic alu_f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b010, 3'b100, 3'b110, 3'b111: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operation for EXECR/EXECI; funct7b5 selects sub only for R-type,
    // because in I-type instructions that bit belongs to the immediate
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_reg);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b100:  ctl = ALU_XOR;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic             illegal_r;
    logic             retire_r;
    logic [CNT_W-1:0] retire_cnt_r;
    logic             decode_illegal_s;
    logic             retire_evt_s;

    logic             pc_write_s;
    logic             ir_write_s;
    logic             reg_write_s;
    logic             mem_write_s;
    logic             adr_src_s;
    logic [1:0]       alu_src_a_s;
    logic [1:0]       alu_src_b_s;
    logic [1:0]       result_src_s;
    logic [2:0]       alu_control_s;

    // Instruction legality, judged from the fields visible during DECODE
    always_comb begin
        case (op)
            OP_LOAD, OP_STORE, OP_JAL: decode_illegal_s = 1'b0;
            OP_REG, OP_IMM:            decode_illegal_s = ~alu_f3_legal(funct3);
            OP_BRANCH:                 decode_illegal_s = (funct3 != 3'b000);
            default:                   decode_illegal_s = 1'b1;
        endcase
    end

    // Next-state logic and detection of the retiring transition into FETCH
    always_comb begin
        next_state_s = state_r;
        retire_evt_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (decode_illegal_s) begin
                    if (TRAP_ON_ILLEGAL != 1'b0) begin
                        next_state_s = S_TRAP;
                    end else begin
                        // illegal instruction completes as a NOP
                        next_state_s = S_FETCH;
                        retire_evt_s = 1'b1;
                    end
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                        OP_REG:            next_state_s = S_EXECR;
                        OP_IMM:            next_state_s = S_EXECI;
                        OP_BRANCH:         next_state_s = S_BEQ;
                        OP_JAL:            next_state_s = S_JAL;
                        default:           next_state_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                next_state_s = S_FETCH;
                retire_evt_s = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                    retire_evt_s = 1'b1;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXECR, S_EXECI: next_state_s = S_ALUWB;
            S_ALUWB: begin
                next_state_s = S_FETCH;
                retire_evt_s = 1'b1;
            end
            S_BEQ: begin
                next_state_s = S_FETCH;
                retire_evt_s = 1'b1;
            end
            S_JAL:  next_state_s = S_ALUWB;
            S_TRAP: next_state_s = S_TRAP;
            default: next_state_s = S_FETCH;
        endcase
    end

    // State register, sticky trap flag, retire pulse and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_FETCH;
            illegal_r    <= 1'b0;
            retire_r     <= 1'b0;
            retire_cnt_r <= '0;
        end else begin
            state_r  <= next_state_s;
            retire_r <= retire_evt_s;
            if (retire_evt_s) begin
                retire_cnt_r <= retire_cnt_r + CNT_ONE;
            end else begin
                retire_cnt_r <= retire_cnt_r;
            end
            if (next_state_s == S_TRAP) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    // Datapath controls decoded from the current state and live handshakes
    always_comb begin
        pc_write_s    = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        mem_write_s   = 1'b0;
        adr_src_s     = 1'b0;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        result_src_s  = 2'b00;
        alu_control_s = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                // held for the whole stall so the memory sees a stable request
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = alu_decode(funct3, funct7b5, 1'b1);
            end
            S_EXECI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_decode(funct3, funct7b5, 1'b0);
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = ALU_SUB;
                pc_write_s    = zero;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_TRAP: begin
                alu_control_s = ALU_ADD;
            end
            default: begin
                alu_control_s = ALU_ADD;
            end
        endcase
    end

    // Strobes are gated by reset so nothing is written while reset is held,
    // even though FETCH would otherwise follow mem_ready.
    assign pc_write    = pc_write_s  & reset;
    assign ir_write    = ir_write_s  & reset;
    assign reg_write   = reg_write_s & reset;
    assign mem_write   = mem_write_s & reset;
    assign adr_src     = adr_src_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign result_src  = result_src_s;
    assign alu_control = alu_control_s;
    assign state       = state_r;
    assign illegal     = illegal_r;
    assign retire      = retire_r;
    assign retire_cnt  = retire_cnt_r;

endmodule
